dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- Parametrised ping-pong NxN transpose buffer between the row and column passes of the separable DCT/IDCT pipeline.
- Accepts one row per handshake and emits the completed block one column per handshake.
- Carries the sob/eob/sof block framing through the buffer.
- Adds valid/ready backpressure and framing-error detection; the fixed 8x8 wrappers have neither.

Parameters:
- N, 8, block dimension (rows = columns = N); legal range 2..16.
- W, 16, bits per sample; data is treated as opaque, with no arithmetic.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  N*W  row samples, element i = column i.
- in_sob  in  1  first row of block.
- in_eob  in  1  last row of block.
- in_sof  in  1  first block of frame; meaningful only with in_sob.
- out_valid  out  1  output column valid.
- out_ready  in  1  downstream accepts the column.
- out_data  out  N*W  column samples, element r = row r.
- out_sob  out  1  first column of block.
- out_eob  out  1  last column of block.
- out_sof  out  1  frame start, on the first column only.
- err_sync  out  1  one-cycle pulse on a framing error.

Behaviour:
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready. out_* hold stable while out_valid && !out_ready.
- Storage: two banks of N*N*W registers; per bank a full flag and a stored sof bit.
- Write side: wr_bank (1 bit), wr_row (log2 N bits).
  - in_ready = !full[wr_bank].
  - Each transfer writes in_data into row wr_row of wr_bank.
  - On the transfer with wr_row == N-1: set full[wr_bank], toggle wr_bank, clear wr_row. Otherwise increment wr_row.
  - The sof bit of the bank is latched from the row-0 transfer.
- Read side: rd_bank, rd_col.
  - out_valid = full[rd_bank].
  - out_data[r] = bank[rd_bank][r][rd_col].
  - out_sob = (rd_col == 0); out_eob = (rd_col == N-1); out_sof = sof[rd_bank] && (rd_col == 0).
  - On the transfer with rd_col == N-1: clear full[rd_bank], toggle rd_bank, clear rd_col. Otherwise increment rd_col.
- Latency and throughput:
  - The first column is valid the cycle after the transfer of row N-1.
  - Sustained throughput is 1 row/cycle in and 1 column/cycle out with no bubbles while out_ready = 1.
- Framing:
  - in_sob with wr_row != 0: discard the partial block, restart at row 0 with this row, pulse err_sync.
  - Row 0 without in_sob: accepted as row 0, err_sync pulses.
  - in_eob asserted with wr_row != N-1: err_sync pulses; the row is still written and the counter is unaffected.
  - Row N-1 without in_eob: block completes, err_sync pulses.
- Simultaneous events:
  - Write completing bank A in the same cycle as read completing bank B: both flag updates apply independently.
  - When the read frees the bank the writer is waiting on, in_ready rises the next cycle, not combinationally from out_ready.
- Both banks full: in_ready = 0 until a drain completes.
- Reset values:
  - All full flags = 0, counters = 0, banks = 0 (not required for data).
  - Outputs: in_ready = 1; out_valid = 0; out_sob/out_eob/out_sof = 0 while invalid; err_sync = 0.
  - Reset mid-block discards all contents; out_valid drops the cycle after rst is sampled.

Optional Feature:
- Macro DCT_TBUF_MODE_EN.
- Defined: adds input port in_transpose (1 bit), latched per bank on the row-0 transfer.
  - 1 gives transposed output, as above.
  - 0 gives row-order output: out_data = bank[rd_bank][rd_col] (row rd_col, element i = column i), with the same framing and latency.
- Undefined: no port; always transposes.

Decomposition:
- Package dct_tbuf_pkg:
  - localparams for counter width $clog2(N);
  - typedef row_t = logic [N-1:0][W-1:0];
  - typedef ctrl_t = struct {sob, eob, sof}.
- Natural sub-module dct_tbuf_bank: one NxN register bank with row write port and selectable column/row read port. It is instantiated twice.

Test Plan:
- Single block, N=8, W=16: in_data row r element c = 16*r+c, sof=1; out_ready=1 throughout.
  - Response: column c appears the cycle after row 7 plus c, out_data[r] = 16*r+c.
  - out_sob on c=0, out_sof on c=0 only, out_eob on c=7, err_sync never pulses.
- Back-to-back 4 blocks, out_ready=1 → in_ready stays 1, 32 columns out contiguous, no bubbles, block order preserved.
- Backpressure: out_ready=0 while 3 blocks are offered.
  - Response: in_ready falls after 16 rows; the third block's row 0 stalls.
  - out_data stays constant while stalled.
  - Raising out_ready drains all 24 columns in order.
- Framing: in_sob on row 3 → err_sync pulses once, the partial block is dropped, and the next output block contains the restarted data. in_eob on row 5 → err_sync pulses, the block still completes at row 7.
- Reset mid-drain: assert rst at column 4 of bank 0 while bank 1 is full → out_valid = 0 the next cycle, in_ready = 1, a new block then outputs correctly.
- With DCT_TBUF_MODE_EN, in_transpose=0 → rows emerge unchanged, element c of output r = 16*r+c.

Source files
------------

// File: rtl/dct_tbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_tbuf_pkg
// Description : Shared types and helpers for the DCT ping-pong transpose
//               buffer (default geometry, row type, framing struct).
// Revision    : 1.0 - initial release
// ============================================================================
package dct_tbuf_pkg;

  localparam int C_N_DEFAULT = 8;
  localparam int C_W_DEFAULT = 16;

  // One row of samples at the default geometry, element i = column i.
  typedef logic [C_N_DEFAULT-1:0][C_W_DEFAULT-1:0] row_t;

  // Block framing carried alongside each row / column.
  typedef struct packed {
    logic sob;
    logic eob;
    logic sof;
  } ctrl_t;

  // Width of a row/column counter for an NxN block (never zero).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dct_tbuf_bank.sv
`default_nettype none
// ============================================================================
// Module      : dct_tbuf_bank
// Description : One NxN sample bank. Whole-row write port; read port returns
//               either column i_rd_idx (transpose) or row i_rd_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_tbuf_bank
  import dct_tbuf_pkg::*;
#(
  parameter int N  = C_N_DEFAULT,
  parameter int W  = C_W_DEFAULT,
  parameter int CW = cnt_width(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [CW-1:0]       i_wr_row,
  input  logic [N-1:0][W-1:0] i_wr_data,
  input  logic [CW-1:0]       i_rd_idx,
  input  logic                i_transpose,
  output logic [N-1:0][W-1:0] o_rd_data
);

  // r_mem[row][col]
  logic [N-1:0][N-1:0][W-1:0] r_mem;

  // Row write; contents cleared on reset so a restarted pipe starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  // Element gi of the read word: row gi of the selected column, or
  // column gi of the selected row when not transposing.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      assign o_rd_data[gi] = i_transpose ? r_mem[gi][i_rd_idx]
                                         : r_mem[i_rd_idx][gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dct_transpose_buf.sv
`default_nettype none
// ============================================================================
// Module      : dct_transpose_buf
// Description : Ping-pong NxN transpose buffer between DCT row and column
//               passes. Rows in, columns out, valid/ready on both sides,
//               sob/eob/sof framing carried through, err_sync on framing
//               errors.
//               Optional macro DCT_TBUF_MODE_EN adds in_transpose (latched
//               per bank on row 0); 0 selects row-order output.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose_buf
  import dct_tbuf_pkg::*;
#(
  parameter int N = C_N_DEFAULT,
  parameter int W = C_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_sob,
  input  logic           in_eob,
  input  logic           in_sof,
`ifdef DCT_TBUF_MODE_EN
  input  logic           in_transpose,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_sob,
  output logic           out_eob,
  output logic           out_sof,
  output logic           err_sync
);

  localparam int            CW     = cnt_width(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [1:0]    r_full;
  logic [1:0]    r_sof;
  logic [1:0]    r_tr;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_wr_row;
  logic [CW-1:0] r_rd_col;
  logic          r_err;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_restart;
  logic [CW-1:0]       w_row_idx;
  logic                w_row_first;
  logic                w_row_last;
  logic                w_frame_err;
  logic                w_tr_in;
  logic [N-1:0][W-1:0] w_in_row;
  logic [N-1:0][W-1:0] w_bank_rd [2];
  ctrl_t               w_in_ctrl;
  ctrl_t               w_out_ctrl;

`ifdef DCT_TBUF_MODE_EN
  assign w_tr_in = in_transpose;
`else
  assign w_tr_in = 1'b1;
`endif

  assign w_in_row   = in_data;
  assign w_in_ctrl  = '{sob: in_sob, eob: in_eob, sof: in_sof};
  assign in_ready   = ~r_full[r_wr_bank];
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = r_full[r_rd_bank];
  assign w_out_xfer = out_valid & out_ready;

  // An sob mid-block drops the partial block: this row becomes row 0.
  assign w_restart   = w_in_ctrl.sob & (r_wr_row != '0);
  assign w_row_idx   = w_restart ? '0 : r_wr_row;
  assign w_row_first = (w_row_idx == '0);
  assign w_row_last  = (w_row_idx == C_LAST);
  assign w_frame_err = w_restart
                     | (w_row_first & ~w_in_ctrl.sob)
                     | (w_in_ctrl.eob & ~w_row_last)
                     | (w_row_last & ~w_in_ctrl.eob);

  // Write/read pointers, per-bank full/sof/mode flags and error pulse.
  // Writer only targets a non-full bank and reader only a full one, so the
  // set and clear of r_full never hit the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_sof     <= '0;
      r_tr      <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_in_xfer & w_frame_err;
      if (w_in_xfer) begin
        if (w_row_first) begin
          r_sof[r_wr_bank] <= w_in_ctrl.sof & w_in_ctrl.sob;
          r_tr[r_wr_bank]  <= w_tr_in;
        end
        if (w_row_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_row          <= '0;
        end else begin
          r_wr_row <= w_row_idx + CW'(1);
        end
      end
      if (w_out_xfer) begin
        if (r_rd_col == C_LAST) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank         <= ~r_rd_bank;
          r_rd_col          <= '0;
        end else begin
          r_rd_col <= r_rd_col + CW'(1);
        end
      end
    end
  end

  generate
    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
      dct_tbuf_bank #(
        .N  (N),
        .W  (W),
        .CW (CW)
      ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_in_xfer & (r_wr_bank == 1'(gb))),
        .i_wr_row    (w_row_idx),
        .i_wr_data   (w_in_row),
        .i_rd_idx    (r_rd_col),
        .i_transpose (r_tr[gb]),
        .o_rd_data   (w_bank_rd[gb])
      );
    end
  endgenerate

  // Output framing is forced low while no column is valid.
  assign w_out_ctrl = '{sob: out_valid & (r_rd_col == '0),
                        eob: out_valid & (r_rd_col == C_LAST),
                        sof: out_valid & r_sof[r_rd_bank] & (r_rd_col == '0)};

  assign out_data = w_bank_rd[r_rd_bank];
  assign out_sob  = w_out_ctrl.sob;
  assign out_eob  = w_out_ctrl.eob;
  assign out_sof  = w_out_ctrl.sof;
  assign err_sync = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dct_transpose_buf
// Description : Directed self-checking bench for dct_transpose_buf (N=8,W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_transpose_buf;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, in_sob, in_eob, in_sof;
  logic           out_valid, out_ready, out_sob, out_eob, out_sof, err_sync;
  logic [N*W-1:0] in_data, out_data;
`ifdef DCT_TBUF_MODE_EN
  logic           in_transpose;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_cnt = 0;
  int stall_cnt = 0;
  int t_last = 0;

  typedef struct {
    logic [N*W-1:0] data;
    logic           sob;
    logic           eob;
    logic           sof;
    int             stamp;
  } col_rec_t;

  col_rec_t q[$];
  col_rec_t mon_rec;

  dct_transpose_buf #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sob    (in_sob),
    .in_eob    (in_eob),
    .in_sof    (in_sof),
`ifdef DCT_TBUF_MODE_EN
    .in_transpose (in_transpose),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .out_sof   (out_sof),
    .err_sync  (err_sync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every column transfer and count err_sync pulses.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_rec.data  = out_data;
      mon_rec.sob   = out_sob;
      mon_rec.eob   = out_eob;
      mon_rec.sof   = out_sof;
      mon_rec.stamp = cyc;
      q.push_back(mon_rec);
    end
    if (err_sync) err_cnt = err_cnt + 1;
  end

  function automatic logic [W-1:0] val(input int k, input int r, input int c);
    return W'(256 * k + 16 * r + c);
  endfunction

  function automatic logic [N*W-1:0] row_of(input int k, input int r);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = val(k, r, c);
    return v;
  endfunction

  function automatic logic [N*W-1:0] col_of(input int k, input int c);
    logic [N*W-1:0] v;
    for (int r = 0; r < N; r++) v[r*W +: W] = val(k, r, c);
    return v;
  endfunction

  // Offer one row; entered and left just after a rising edge.
  task automatic push_row(input logic [N*W-1:0] d, input logic sob,
                          input logic eob, input logic sof);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d; in_sob = sob; in_eob = eob; in_sof = sof;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      stall_cnt = stall_cnt + 1;
      waited = waited + 1;
      if (waited > 300) begin
        total = total + 1; bad = bad + 1;
        $display("FAIL push_timeout: in_ready=0 for %0d cycles, required 1", waited);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    t_last = cyc;
    in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
  endtask

  task automatic push_block(input int k, input logic sof);
    for (int r = 0; r < N; r++)
      push_row(row_of(k, r), r == 0, r == N - 1, sof && (r == 0));
  endtask

  // Bounded wait for a number of captured columns beyond base.
  task automatic wait_cols(input int base, input int n, input int budget);
    int w;
    w = 0;
    while (q.size() < base + n && w < budget) begin
      @(posedge clk); #1;
      w = w + 1;
    end
    total = total + 1;
    if (q.size() < base + n) begin
      bad = bad + 1;
      $display("FAIL col_timeout: got %0d columns, required %0d", q.size() - base, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 5;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    if ({out_sob, out_eob, out_sof} !== 3'b000) begin bad++; $display("FAIL rst_framing: got %b exp 000", {out_sob, out_eob, out_sof}); end
    if (err_sync !== 1'b0) begin bad++; $display("FAIL rst_err_sync: got %b exp 0", err_sync); end
    if (q.size() !== 0) begin bad++; $display("FAIL rst_no_output: got %0d cols exp 0", q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_block();
    int base, e0, t7;
    base = q.size(); e0 = err_cnt;
    out_ready = 1'b1;
    push_block(1, 1'b1);
    t7 = t_last;
    wait_cols(base, N, 50);
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      total += 3;
      if (q[base+c].data !== col_of(1, c)) begin bad++; $display("FAIL single_data c=%0d: got %h exp %h", c, q[base+c].data, col_of(1, c)); end
      if ({q[base+c].sob, q[base+c].eob, q[base+c].sof} !== {c == 0, c == N - 1, c == 0}) begin
        bad++; $display("FAIL single_framing c=%0d: got %b exp %b", c, {q[base+c].sob, q[base+c].eob, q[base+c].sof}, {c == 0, c == N - 1, c == 0});
      end
      if (q[base+c].stamp !== t7 + c) begin bad++; $display("FAIL single_latency c=%0d: got cycle %0d exp %0d", c, q[base+c].stamp, t7 + c); end
    end
    total += 2;
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL single_err: got %0d pulses exp 0", err_cnt - e0); end
    if (q.size() !== base + N) begin bad++; $display("FAIL single_count: got %0d cols exp %0d", q.size() - base, N); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = q.size();
    out_ready = 1'b1;
    stall_cnt = 0;
    for (int k = 2; k < 6; k++) push_block(k, k == 2);
    wait_cols(base, 4 * N, 80);
    total += 1;
    if (stall_cnt !== 0) begin bad++; $display("FAIL b2b_in_ready: got %0d stalls exp 0", stall_cnt); end
    for (int i = 0; i < 4 * N; i++) begin
      total += 3;
      if (q[base+i].data !== col_of(2 + i / N, i % N)) begin bad++; $display("FAIL b2b_data i=%0d: got %h exp %h", i, q[base+i].data, col_of(2 + i / N, i % N)); end
      if (q[base+i].stamp !== q[base].stamp + i) begin bad++; $display("FAIL b2b_bubble i=%0d: got cycle %0d exp %0d", i, q[base+i].stamp, q[base].stamp + i); end
      if (q[base+i].sof !== (i == 0)) begin bad++; $display("FAIL b2b_sof i=%0d: got %b exp %b", i, q[base+i].sof, i == 0); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [N*W-1:0] snap;
    repeat (4) @(posedge clk);
    #1;
    base = q.size();
    out_ready = 1'b0;
    push_block(10, 1'b1);
    push_block(11, 1'b0);
    @(negedge clk);
    total += 3;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low: got %b exp 0", in_ready); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b exp 1", out_valid); end
    if (out_data !== col_of(10, 0)) begin bad++; $display("FAIL bp_first_col: got %h exp %h", out_data, col_of(10, 0)); end
    snap = out_data;
    repeat (5) @(negedge clk);
    total += 3;
    if (out_data !== snap) begin bad++; $display("FAIL bp_hold_data: got %h exp %h", out_data, snap); end
    if (out_sob !== 1'b1) begin bad++; $display("FAIL bp_hold_sob: got %b exp 1", out_sob); end
    if (q.size() !== base) begin bad++; $display("FAIL bp_no_drain: got %0d cols exp 0", q.size() - base); end
    @(posedge clk); #1;
    stall_cnt = 0;
    fork
      push_block(12, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_cols(base, 3 * N, 100);
    total += 1;
    if (stall_cnt < 4) begin bad++; $display("FAIL bp_third_stall: got %0d stalls exp >=4", stall_cnt); end
    for (int i = 0; i < 3 * N; i++) begin
      total += 1;
      if (q[base+i].data !== col_of(10 + i / N, i % N)) begin bad++; $display("FAIL bp_order i=%0d: got %h exp %h", i, q[base+i].data, col_of(10 + i / N, i % N)); end
    end
  endtask

  task automatic test_framing();
    int base, e0;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = q.size(); e0 = err_cnt;
    for (int r = 0; r < 3; r++) push_row(row_of(20, r), r == 0, 1'b0, r == 0);
    push_block(21, 1'b1);
    wait_cols(base, N, 50);
    repeat (4) @(posedge clk);
    #1;
    total += 3;
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL frm_restart_err: got %0d pulses exp 1", err_cnt - e0); end
    if (q.size() !== base + N) begin bad++; $display("FAIL frm_partial_dropped: got %0d cols exp %0d", q.size() - base, N); end
    if (q[base].sof !== 1'b1) begin bad++; $display("FAIL frm_restart_sof: got %b exp 1", q[base].sof); end
    for (int c = 0; c < N; c++) begin
      total += 1;
      if (q[base+c].data !== col_of(21, c)) begin bad++; $display("FAIL frm_restart_data c=%0d: got %h exp %h", c, q[base+c].data, col_of(21, c)); end
    end
    base = q.size(); e0 = err_cnt;
    for (int r = 0; r < N; r++) push_row(row_of(22, r), r == 0, (r == 5) || (r == N - 1), 1'b0);
    wait_cols(base, N, 50);
    repeat (4) @(posedge clk);
    #1;
    total += 2;
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL frm_eob_err: got %0d pulses exp 1", err_cnt - e0); end
    if (q.size() !== base + N) begin bad++; $display("FAIL frm_eob_count: got %0d cols exp %0d", q.size() - base, N); end
    for (int c = 0; c < N; c++) begin
      total += 1;
      if (q[base+c].data !== col_of(22, c)) begin bad++; $display("FAIL frm_eob_data c=%0d: got %h exp %h", c, q[base+c].data, col_of(22, c)); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int base, b2;
    base = q.size();
    out_ready = 1'b0;
    push_block(30, 1'b1);
    push_block(31, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rmd_out_valid: got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rmd_in_ready: got %b exp 1", in_ready); end
    if (q.size() !== base + 4) begin bad++; $display("FAIL rmd_partial_cols: got %0d exp 4", q.size() - base); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    b2 = q.size();
    push_block(32, 1'b1);
    wait_cols(b2, N, 50);
    repeat (6) @(posedge clk);
    #1;
    total += 1;
    if (q.size() !== b2 + N) begin bad++; $display("FAIL rmd_new_count: got %0d cols exp %0d", q.size() - b2, N); end
    for (int c = 0; c < N; c++) begin
      total += 1;
      if (q[b2+c].data !== col_of(32, c)) begin bad++; $display("FAIL rmd_new_data c=%0d: got %h exp %h", c, q[b2+c].data, col_of(32, c)); end
    end
  endtask

`ifdef DCT_TBUF_MODE_EN
  task automatic test_row_mode();
    int base;
    base = q.size();
    out_ready = 1'b1;
    in_transpose = 1'b0;
    push_row(row_of(40, 0), 1'b1, 1'b0, 1'b1);
    in_transpose = 1'b1;
    for (int r = 1; r < N; r++) push_row(row_of(40, r), 1'b0, r == N - 1, 1'b0);
    wait_cols(base, N, 50);
    for (int r = 0; r < N; r++) begin
      total += 1;
      if (q[base+r].data !== row_of(40, r)) begin bad++; $display("FAIL row_mode r=%0d: got %h exp %h", r, q[base+r].data, row_of(40, r)); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
`ifdef DCT_TBUF_MODE_EN
    in_transpose = 1'b1;
`endif
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_mid_drain();
`ifdef DCT_TBUF_MODE_EN
    test_row_mode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
